sigmoid: RTL and testbench
==========================

Name: sigmoid

Overview:
- Pipelined piecewise-linear sigmoid segment evaluator: alfa = gradient·x + offset, all signed fixed-point.
- Segment gradient and offset are chosen upstream (segment-select logic / coefficient ROM) and presented alongside x.
- Output is clamped to the sigmoid range [0, 1.0] and feeds the VAE datapath.

Parameters:
- BITS, 16, total word width of x, gradient, offset and alfa (signed two's complement).
- FRAC, 8, fractional bits (Q(BITS-FRAC).FRAC; default Q8.8, 1 LSB = 1/256).
- CLAMP_UNIT, 1, 1 = clamp result to [0, 1.0]; 0 = saturate to the full signed BITS range only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/gradient/offset valid this cycle.
- x  input  BITS  signed input sample, QFRAC.
- gradient  input  BITS  signed segment slope, QFRAC.
- offset  input  BITS  signed segment intercept, QFRAC.
- out_valid  output  1  alfa valid this cycle.
- alfa  output  BITS  signed result, QFRAC.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n = 0, all pipeline registers, alfa and out_valid are 0. No other reset state exists.
- No backpressure:
  - Every cycle with in_valid = 1 produces exactly one result, with out_valid = 1, exactly 2 cycles later.
  - Back-to-back inputs are accepted every cycle.
- When in_valid = 0, stage registers still load (data is don't-care), but the valid bit propagates as 0.
- alfa holds its last value while out_valid = 0.
- Stage 1 (registered):
  - p = signed(x) · signed(gradient), full 2·BITS-bit product.
  - offset is captured alongside p.
- Stage 2 (registered):
  - q = p >>> FRAC. Arithmetic shift, i.e. truncation toward −∞; no rounding.
  - s = q + sign-extended offset, computed in 2·BITS+1 bits, so no intermediate overflow.
  - CLAMP_UNIT = 1: alfa = 0 if s < 0; alfa = 2^FRAC (0x0100) if s > 2^FRAC; else s.
  - CLAMP_UNIT = 0: alfa = s saturated to [−2^(BITS−1), 2^(BITS−1)−1].
- Boundaries:
  - Small products truncate to 0 or −1 LSB per floor semantics. Example: 127·2 = 254 → 0; −1·1 → −1.
  - The extreme product (−2^(BITS−1))² must not wrap; it saturates or clamps.
- rst_n asserted mid-operation flushes both stages immediately. No valid output emerges for inputs accepted before reset.
- Purely synchronous datapath apart from the reset. No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n = 0 with random inputs and in_valid = 1 → alfa = 0x0000 and out_valid = 0 throughout. Release → first out_valid 2 cycles after the first in_valid.
- Directed vectors, one per cycle, CLAMP_UNIT = 1 (x, gradient, offset → alfa, 2 cycles later):
  - 0x0001, 0x0002, 0x0000 → 0x0000
  - 0x000C, 0x0004, 0x0001 → 0x0001
  - 0x0000, 0x0000, 0x0000 → 0x0000
  - 0x007F, 0x0002, 0x0001 → 0x0001
  - 0xFF80, 0xFFFE, 0xFFFF → 0x0000
- Clamp, CLAMP_UNIT = 1:
  - x = 0x0400, gradient = 0x0100, offset = 0x0080 → 0x0100.
  - x = 0xFC00, gradient = 0x0100, offset = 0 → 0x0000.
  - Midpoint: x = 0, gradient = 0x0040, offset = 0x0080 → 0x0080.
- Saturation, CLAMP_UNIT = 0:
  - x = 0x7FFF, gradient = 0x7FFF, offset = 0x7FFF → 0x7FFF.
  - x = 0x8000, gradient = 0x7FFF, offset = 0x8000 → 0x8000.
  - x = 0x8000, gradient = 0x8000 → 0x7FFF.
  - x = 0xFFFF, gradient = 0x0001, offset = 0 → 0xFFFF (floor).
- Throughput/gaps: random stream with in_valid toggling randomly → out_valid equals in_valid delayed 2 cycles. Each alfa matches the reference model; alfa is stable while out_valid = 0.
- Reset mid-stream: assert rst_n low for 1 cycle with 2 inputs in flight → outputs clear immediately and neither in-flight result appears. The next accepted input yields a correct result after 2 cycles.

Source files
------------

// File: rtl/sigmoid.sv
// Two-stage piecewise-linear sigmoid segment: alfa = (x * gradient) >>> FRAC + offset,
// clamped to [0, 1.0] or saturated to the signed word range.
module sigmoid #(
    parameter int BITS       = 16,
    parameter int FRAC       = 8,
    parameter int CLAMP_UNIT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic signed [BITS-1:0] x,
    input  logic signed [BITS-1:0] gradient,
    input  logic signed [BITS-1:0] offset,
    output logic                   out_valid,
    output logic signed [BITS-1:0] alfa
);

    localparam int PW = 2 * BITS;
    localparam int SW = 2 * BITS + 1;

    localparam logic signed [SW-1:0] MAX_S  = {{(SW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S  = {{(SW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    localparam logic signed [SW-1:0] ONE_S  = {{(SW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [SW-1:0] ZERO_S = '0;

    logic signed [PW-1:0]   p_reg;
    logic signed [BITS-1:0] off_reg;
    logic                   v1_reg;

    logic signed [PW-1:0]   q_next;
    logic signed [SW-1:0]   s_next;
    logic signed [BITS-1:0] alfa_next;
    logic signed [BITS-1:0] alfa_reg;
    logic                   valid_reg;

    // Stage 1: full-width product, offset travels alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg   <= '0;
            off_reg <= '0;
            v1_reg  <= 1'b0;
        end else begin
            p_reg   <= x * gradient;
            off_reg <= offset;
            v1_reg  <= in_valid;
        end
    end

    // Floor-shift then add in one extra bit so the sum can never wrap.
    always_comb begin
        q_next = p_reg >>> FRAC;
        s_next = {q_next[PW-1], q_next} + {{(SW-BITS){off_reg[BITS-1]}}, off_reg};
    end

    generate
        if (CLAMP_UNIT != 0) begin : g_clamp
            always_comb begin
                alfa_next = s_next[BITS-1:0];
                if (s_next < ZERO_S) begin
                    alfa_next = '0;
                end else if (s_next > ONE_S) begin
                    alfa_next = ONE_S[BITS-1:0];
                end
            end
        end else begin : g_sat
            always_comb begin
                alfa_next = s_next[BITS-1:0];
                if (s_next > MAX_S) begin
                    alfa_next = MAX_S[BITS-1:0];
                end else if (s_next < MIN_S) begin
                    alfa_next = MIN_S[BITS-1:0];
                end
            end
        end
    endgenerate

    // Stage 2: alfa only updates on a valid result and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alfa_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= v1_reg;
            if (v1_reg) begin
                alfa_reg <= alfa_next;
            end
        end
    end

    assign alfa      = alfa_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_sigmoid.sv
// Scoreboard bench for sigmoid: one clamped and one saturating instance share stimulus.
module tb_sigmoid;

    typedef struct {
        logic [15:0] v;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] gradient = '0;
    logic [15:0] offset = '0;
    logic        out_valid1, out_valid0;
    logic [15:0] alfa1, alfa0;

    exp_t        q1[$];
    exp_t        q0[$];
    logic [15:0] prev[2];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sigmoid #(.BITS(16), .FRAC(8), .CLAMP_UNIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .gradient(gradient),
        .offset(offset), .out_valid(out_valid1), .alfa(alfa1)
    );

    sigmoid #(.BITS(16), .FRAC(8), .CLAMP_UNIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .gradient(gradient),
        .offset(offset), .out_valid(out_valid0), .alfa(alfa0)
    );

    function automatic logic [15:0] model(input logic [15:0] xv, input logic [15:0] gv,
                                          input logic [15:0] ov, input bit clamp);
        longint p;
        longint s;
        p = longint'($signed(xv)) * longint'($signed(gv));
        s = (p >>> 8) + longint'($signed(ov));
        if (clamp) begin
            if (s < 0) s = 0;
            else if (s > 256) s = 256;
        end else begin
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
        end
        return s[15:0];
    endfunction

    task automatic send(input logic [15:0] xv, input logic [15:0] gv, input logic [15:0] ov,
                        input logic [15:0] e1, input logic [15:0] e0);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = xv;
        gradient = gv;
        offset = ov;
        e.cyc = cycle;
        e.v = e1;
        q1.push_back(e);
        e.v = e0;
        q0.push_back(e);
        $display("issue cyc=%0d x=%h g=%h o=%h exp_clamp=%h exp_sat=%h", cycle, xv, gv, ov, e1, e0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            x = 16'($urandom);
            gradient = 16'($urandom);
            offset = 16'($urandom);
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic [15:0] a);
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (ov !== 1'b0 || a !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state inst=%0d: got valid=%b alfa=%h, need 0/0000", id, ov, a);
            end
            prev[id] = a;
            return;
        end
        if (ov) begin
            checks++;
            if ((id == 1 && q1.size() == 0) || (id == 0 && q0.size() == 0)) begin
                errors++;
                $display("FAIL spurious_valid inst=%0d cyc=%0d: got alfa=%h, need no output", id, cycle, a);
            end else begin
                e = (id == 1) ? q1.pop_front() : q0.pop_front();
                if (a !== e.v || cycle != e.cyc + 2) begin
                    errors++;
                    $display("FAIL result inst=%0d: got alfa=%h at cyc %0d, need %h at cyc %0d",
                             id, a, cycle, e.v, e.cyc + 2);
                end else begin
                    $display("result inst=%0d cyc=%0d alfa=%h ok", id, cycle, a);
                end
            end
        end else begin
            checks++;
            if (a !== prev[id]) begin
                errors++;
                $display("FAIL hold inst=%0d cyc=%0d: got alfa=%h, need %h", id, cycle, a, prev[id]);
            end
            if (id == 1 && q1.size() > 0 && q1[0].cyc + 2 <= cycle) begin
                e = q1.pop_front();
                errors++;
                $display("FAIL missing inst=1 cyc=%0d: got no valid, need alfa=%h", cycle, e.v);
            end
            if (id == 0 && q0.size() > 0 && q0[0].cyc + 2 <= cycle) begin
                e = q0.pop_front();
                errors++;
                $display("FAIL missing inst=0 cyc=%0d: got no valid, need alfa=%h", cycle, e.v);
            end
        end
        prev[id] = a;
    endtask

    always @(negedge clk) begin
        mon(1, out_valid1, alfa1);
        mon(0, out_valid0, alfa0);
    end

    initial begin
        logic [15:0] rx, rg, ro;
        // Reset held with live random inputs.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            x = 16'($urandom);
            gradient = 16'($urandom);
            offset = 16'($urandom);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Directed floor-semantics vectors, back to back.
        send(16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000);
        send(16'h000C, 16'h0004, 16'h0001, 16'h0001, 16'h0001);
        send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        send(16'h007F, 16'h0002, 16'h0001, 16'h0001, 16'h0001);
        send(16'hFF80, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000);
        // Clamp region.
        send(16'h0400, 16'h0100, 16'h0080, 16'h0100, 16'h0480);
        send(16'hFC00, 16'h0100, 16'h0000, 16'h0000, 16'hFC00);
        send(16'h0000, 16'h0040, 16'h0080, 16'h0080, 16'h0080);
        // Saturation extremes.
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h7FFF);
        send(16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000);
        send(16'h8000, 16'h8000, 16'h0000, 16'h0100, 16'h7FFF);
        send(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF);
        idle(3);

        // Random stream with gaps; small gradients keep results inside the unit range often.
        for (int i = 0; i < 150; i++) begin
            rx = 16'($urandom);
            rg = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            ro = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                send(rx, rg, ro, model(rx, rg, ro, 1'b1), model(rx, rg, ro, 1'b0));
            end else begin
                idle(1);
            end
        end
        idle(3);

        // Reset with work in flight: neither in-flight result may appear.
        send(16'h0010, 16'h0100, 16'h0020, 16'h0030, 16'h0030);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = 16'h0001;
        gradient = 16'h0100;
        offset = 16'h0001;
        rst_n = 1'b0;
        q1.delete();
        q0.delete();
        $display("reset asserted cyc=%0d with 2 inputs in flight", cycle);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle(2);
        send(16'h0200, 16'h0040, 16'h0010, 16'h0090, 16'h0090);
        idle(4);

        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, need 0/0", q1.size(), q0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
